s38584_sel_scheduler: RTL and testbench

- Round-robin scheduler for the shared select/parity-update datapath in the s38584 partition.
- Arbitrates up to N_REQ requesters for the single select bus. The select code is the 4-bit pattern on the g5644/g5703/g5689/g5659 control bits.
- Holds the granted code stable while the datapath settles, then folds the granted requester's data bit into a parity register.
- The global enable freezes the block. A status-qualification input gates new grants.

---
 rtl/s38584_sched_pkg.sv | 18 +
 rtl/s38584_sel_scheduler_rr_arbiter.sv | 36 +++
 rtl/s38584_sel_scheduler.sv | 130 +++++++++++++
 tb/tb_s38584_sel_scheduler.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/s38584_sched_pkg.sv
// Shared types and default parameters for the s38584 select/parity scheduler.
package s38584_sched_pkg;

   localparam int unsigned SEL_W_DEF    = 4;
   localparam int unsigned N_REQ_DEF    = 16;
   localparam int unsigned HOLD_CYC_DEF = 2;
   localparam int unsigned HOLD_MIN     = 1;
   localparam int unsigned HOLD_MAX     = 15;
   localparam int unsigned CNT_W        = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ARB,
      ST_DRIVE,
      ST_UPDATE
   } state_e;

endpackage

// File: rtl/s38584_sel_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter
   import s38584_sched_pkg::*;
#(
   parameter int unsigned N_REQ = N_REQ_DEF,
   parameter int unsigned SEL_W = SEL_W_DEF
) (
   input  logic [N_REQ-1:0] req,
   input  logic [SEL_W-1:0] ptr,
   output logic [N_REQ-1:0] gnt_nxt,
   output logic [SEL_W-1:0] index,
   output logic             any
);

   logic             found;
   logic [SEL_W-1:0] pos;

   // N_REQ == 2**SEL_W, so the SEL_W-bit add gives the modulo wrap for free
   always_comb begin
      gnt_nxt = '0;
      index   = '0;
      found   = 1'b0;
      pos     = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         pos = ptr + SEL_W'(i);
         if (!found && req[pos]) begin
            found = 1'b1;
            index = pos;
         end
      end
      gnt_nxt[index] = found;
   end

   assign any = |req;

endmodule

// File: rtl/s38584_sel_scheduler.sv
// Round-robin owner of the shared select bus: grants, holds sel for HOLD_CYC
// cycles, then folds the granted requester's data bit into the parity register.
module s38584_sel_scheduler
   import s38584_sched_pkg::*;
#(
   parameter int unsigned N_REQ    = N_REQ_DEF,
   parameter int unsigned SEL_W    = SEL_W_DEF,
   parameter int unsigned HOLD_CYC = HOLD_CYC_DEF
) (
   input  logic             CK,
   input  logic             RST_N,
   input  logic             en,
   input  logic             qual,
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] data_bit,
   input  logic             par_load,
   input  logic             par_init,
   output logic [N_REQ-1:0] gnt,
   output logic [SEL_W-1:0] sel,
   output logic             sel_vld,
   output logic             par_out,
   output logic             par_vld,
   output logic             busy
);

   state_e           state_q,   state_d;
   logic [N_REQ-1:0] gnt_q,     gnt_d;
   logic [SEL_W-1:0] sel_q,     sel_d;
   logic             sel_vld_q, sel_vld_d;
   logic [CNT_W-1:0] cnt_q,     cnt_d;
   logic [SEL_W-1:0] ptr_q,     ptr_d;
   logic             par_q,     par_d;
   logic             par_vld_q, par_vld_d;

   logic [N_REQ-1:0] arb_gnt;
   logic [SEL_W-1:0] arb_idx;
   logic             arb_any;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .SEL_W (SEL_W)
   ) u_arb (
      .req     (req),
      .ptr     (ptr_q),
      .gnt_nxt (arb_gnt),
      .index   (arb_idx),
      .any     (arb_any)
   );

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      sel_d     = sel_q;
      sel_vld_d = sel_vld_q;
      cnt_d     = cnt_q;
      ptr_d     = ptr_q;
      par_d     = par_q;
      par_vld_d = 1'b0;
      if (en) begin
         unique case (state_q)
            ST_IDLE: begin
               if (par_load) begin
                  par_d = par_init;
               end else if (arb_any) begin
                  state_d = ST_ARB;
               end
            end
            ST_ARB: begin
               if (!arb_any) begin
                  state_d = ST_IDLE;
               end else if (qual) begin
                  gnt_d     = arb_gnt;
                  sel_d     = arb_idx;
                  sel_vld_d = 1'b1;
                  cnt_d     = CNT_W'(HOLD_CYC - 1);
                  state_d   = ST_DRIVE;
               end
            end
            // Grant drops on leaving DRIVE so sel_vld spans exactly HOLD_CYC
            // cycles; sel itself stays put so UPDATE can index data_bit with it.
            ST_DRIVE: begin
               if (cnt_q == '0) begin
                  gnt_d     = '0;
                  sel_vld_d = 1'b0;
                  state_d   = ST_UPDATE;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            ST_UPDATE: begin
               par_d     = par_q ^ data_bit[sel_q];
               par_vld_d = 1'b1;
               ptr_d     = sel_q + 1'b1;
               state_d   = arb_any ? ST_ARB : ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge CK) begin
      if (!RST_N) begin
         state_q   <= ST_IDLE;
         gnt_q     <= '0;
         sel_q     <= '0;
         sel_vld_q <= 1'b0;
         cnt_q     <= '0;
         ptr_q     <= '0;
         par_q     <= 1'b0;
         par_vld_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         sel_q     <= sel_d;
         sel_vld_q <= sel_vld_d;
         cnt_q     <= cnt_d;
         ptr_q     <= ptr_d;
         par_q     <= par_d;
         par_vld_q <= par_vld_d;
      end
   end

   assign gnt     = gnt_q;
   assign sel     = sel_q;
   assign sel_vld = sel_vld_q;
   assign par_out = par_q;
   assign par_vld = par_vld_q;
   assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_s38584_sel_scheduler.sv
// Scoreboard bench for s38584_sel_scheduler: expected grants and parity results
// are queued with the stimulus and retired by a negedge monitor.
module tb_s38584_sel_scheduler;

   logic        CK = 1'b0;
   logic        RST_N;
   logic        en;
   logic        qual;
   logic [15:0] req;
   logic [15:0] data_bit;
   logic        par_load;
   logic        par_init;
   logic [15:0] gnt;
   logic [3:0]  sel;
   logic        sel_vld;
   logic        par_out;
   logic        par_vld;
   logic        busy;

   int errors = 0;
   int checks = 0;

   int unsigned gq[$];
   logic        pq[$];

   int   hold_exp  = 2;
   bit   period_on = 1'b0;
   int   last_rise = -1;
   int   cyc       = 0;
   int   run       = 0;
   logic vld_prev  = 1'b0;

   always #5 CK = ~CK;

   s38584_sel_scheduler #(
      .N_REQ    (16),
      .SEL_W    (4),
      .HOLD_CYC (2)
   ) dut (
      .CK       (CK),
      .RST_N    (RST_N),
      .en       (en),
      .qual     (qual),
      .req      (req),
      .data_bit (data_bit),
      .par_load (par_load),
      .par_init (par_init),
      .gnt      (gnt),
      .sel      (sel),
      .sel_vld  (sel_vld),
      .par_out  (par_out),
      .par_vld  (par_vld),
      .busy     (busy)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge CK);
         #1;
      end
   endtask

   task automatic wait_grants(input int budget);
      int n = 0;
      while (gq.size() != 0 && n < budget) begin
         step(1);
         n++;
      end
      if (gq.size() != 0) begin
         chk("grant_timeout", 32'(gq.size()), 32'd0);
         gq.delete();
      end
   endtask

   always @(negedge CK) begin
      int unsigned e;
      logic        pe;
      cyc++;
      if (!sel_vld) chk("gnt_without_vld", 32'(gnt), 32'd0);
      if (sel_vld && !vld_prev) begin
         if (period_on && last_rise >= 0) chk("grant_period", 32'(cyc - last_rise), 32'd4);
         last_rise = cyc;
         if (gq.size() == 0) begin
            chk("grant_unexpected_sel", 32'(sel), 32'hFFFF);
         end else begin
            e = gq.pop_front();
            chk("grant_sel", 32'(sel), e);
            chk("grant_gnt", 32'(gnt), 32'd1 << e);
         end
      end
      if (sel_vld) begin
         run++;
      end else if (vld_prev) begin
         chk("hold_len", 32'(run), 32'(hold_exp));
         run = 0;
      end
      vld_prev = sel_vld;
      if (par_vld) begin
         if (pq.size() == 0) begin
            chk("par_unexpected", 32'(pq.size()), 32'd1);
         end else begin
            pe = pq.pop_front();
            chk("par_out", 32'(par_out), 32'(pe));
         end
      end
   end

   initial begin
      RST_N    = 1'b0;
      en       = 1'b1;
      qual     = 1'b1;
      req      = 16'hFFFF;
      data_bit = 16'h0000;
      par_load = 1'b0;
      par_init = 1'b0;

      // reset with all requests up, then release frozen
      step(2);
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_sel", 32'(sel), 32'd0);
      chk("rst_sel_vld", 32'(sel_vld), 32'd0);
      chk("rst_par_out", 32'(par_out), 32'd0);
      chk("rst_par_vld", 32'(par_vld), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      RST_N = 1'b1;
      en    = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step(1);
         chk("frz_busy", 32'(busy), 32'd0);
         chk("frz_sel_vld", 32'(sel_vld), 32'd0);
      end
      req = 16'h0000;
      en  = 1'b1;
      step(2);

      // round-robin wrap between requesters 0 and 15
      period_on = 1'b1;
      last_rise = -1;
      gq.push_back(0); gq.push_back(15); gq.push_back(0); gq.push_back(15);
      repeat (4) pq.push_back(1'b0);
      req = 16'h8001;
      wait_grants(40);
      req = 16'h0000;
      step(6);
      period_on = 1'b0;
      chk("wrap_par_drained", 32'(pq.size()), 32'd0);

      // qual gating: no grant until qual rises, then one cycle latency
      qual = 1'b0;
      req  = 16'h0010;
      for (int i = 0; i < 6; i++) begin
         step(1);
         chk("qual_gate_gnt", 32'(gnt), 32'd0);
      end
      chk("qual_busy_arb", 32'(busy), 32'd1);
      gq.push_back(4);
      pq.push_back(1'b0);
      qual = 1'b1;
      step(1);
      chk("qual_lat_gnt", 32'(gnt), 32'h0010);
      chk("qual_lat_sel", 32'(sel), 32'd4);
      req = 16'h0000;
      step(6);

      // parity accumulation from a loaded seed
      par_load = 1'b1;
      par_init = 1'b1;
      step(1);
      par_load = 1'b0;
      chk("par_load", 32'(par_out), 32'd1);
      chk("par_load_busy", 32'(busy), 32'd0);
      gq.push_back(0); gq.push_back(1); gq.push_back(2);
      pq.push_back(1'b0); pq.push_back(1'b0); pq.push_back(1'b1);
      req      = 16'h0007;
      data_bit = 16'h0005;
      wait_grants(40);
      req = 16'h0000;
      step(8);
      chk("par_final", 32'(par_out), 32'd1);
      chk("par_drained", 32'(pq.size()), 32'd0);

      // freeze mid-DRIVE stretches the hold by the frozen cycles
      data_bit = 16'h0000;
      hold_exp = 5;
      gq.push_back(1);
      pq.push_back(1'b1);
      req = 16'h0002;
      wait_grants(20);
      en       = 1'b0;
      req      = 16'h0000;
      par_load = 1'b1;
      par_init = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(1);
         chk("frz_sel", 32'(sel), 32'd1);
         chk("frz_gnt", 32'(gnt), 32'h0002);
         chk("frz_par_vld", 32'(par_vld), 32'd0);
      end
      en       = 1'b1;
      par_load = 1'b0;
      step(6);
      hold_exp = 2;
      chk("frz_par_kept", 32'(par_out), 32'd1);
      chk("frz_drained", 32'(pq.size()), 32'd0);

      // reset during DRIVE aborts the update and rewinds the pointer
      gq.push_back(6);
      data_bit = 16'h0040;
      req      = 16'h0040;
      wait_grants(20);
      RST_N = 1'b0;
      step(1);
      chk("mid_rst_par", 32'(par_out), 32'd0);
      chk("mid_rst_sel", 32'(sel), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      gq.push_back(1);
      pq.push_back(1'b0);
      data_bit = 16'h0000;
      req      = 16'h0006;
      RST_N    = 1'b1;
      wait_grants(20);
      req = 16'h0000;
      step(8);

      chk("end_grants_left", 32'(gq.size()), 32'd0);
      chk("end_par_left", 32'(pq.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
